// File: rtl/axis_prbs_checker.sv
// Self-synchronising PRBS-16 (x^16+x^14+x^13+x^11+1) checker for a 16-bit AXI-Stream sink.
// Build option: define AXIS_PRBS_CHK_RESYNC_EN to make CHECK follow received data instead of free-running.
module axis_prbs_checker #(
  parameter int unsigned DATA_W     = 16,
  parameter logic [7:0]  READY_MASK = 8'hFF
) (
  input  logic              s_axis_aclk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       num_words,
  input  logic              s_axis_tvaild,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              locked,
  output logic              done,
  output logic              pass,
  output logic [31:0]       word_cnt,
  output logic [15:0]       err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t            state_q;
  logic              tready_q;
  logic              locked_q;
  logic              done_q;
  logic [2:0]        phase_q;
  logic [31:0]       num_q;
  logic [31:0]       word_cnt_q;
  logic [15:0]       err_cnt_q;
  logic [DATA_W-1:0] exp_q;

  logic              accept_d;
  logic              last_d;
  logic              mismatch_d;
  logic [2:0]        phase_d;
  logic              tready_d;
  logic [31:0]       word_cnt_d;
  logic [15:0]       err_cnt_d;
  logic [DATA_W-1:0] exp_d;

  // 16 unrolled LFSR steps give next(word) in a single cycle.
  logic [16:0][DATA_W-1:0] data_chain;
  assign data_chain[0] = s_axis_tdata;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_data_step
      assign data_chain[gi+1] = {data_chain[gi][DATA_W-2:0],
                                 data_chain[gi][DATA_W-1] ^ data_chain[gi][DATA_W-3] ^
                                 data_chain[gi][DATA_W-4] ^ data_chain[gi][DATA_W-6]};
    end
  endgenerate

`ifdef AXIS_PRBS_CHK_RESYNC_EN
  assign exp_d = data_chain[16];
`else
  logic [16:0][DATA_W-1:0] exp_chain;
  assign exp_chain[0] = exp_q;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_exp_step
      assign exp_chain[gi+1] = {exp_chain[gi][DATA_W-2:0],
                                exp_chain[gi][DATA_W-1] ^ exp_chain[gi][DATA_W-3] ^
                                exp_chain[gi][DATA_W-4] ^ exp_chain[gi][DATA_W-6]};
    end
  endgenerate

  assign exp_d = exp_chain[16];
`endif

  assign accept_d   = s_axis_tvaild & tready_q;
  assign word_cnt_d = word_cnt_q + 32'd1;
  assign last_d     = (word_cnt_d == num_q);
  assign mismatch_d = (s_axis_tdata != exp_q);
  assign err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
  assign phase_d    = phase_q + 3'd1;
  assign tready_d   = READY_MASK[phase_d];

  always_ff @(posedge s_axis_aclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tready_q   <= 1'b0;
      locked_q   <= 1'b0;
      done_q     <= 1'b0;
      phase_q    <= 3'd0;
      num_q      <= 32'd0;
      word_cnt_q <= 32'd0;
      err_cnt_q  <= 16'd0;
      exp_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_q      <= num_words;
            word_cnt_q <= 32'd0;
            err_cnt_q  <= 16'd0;
            locked_q   <= 1'b0;
            phase_q    <= 3'd0;
            if (num_words == 32'd0) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              tready_q <= 1'b0;
            end else begin
              state_q  <= ST_SEED;
              done_q   <= 1'b0;
              tready_q <= READY_MASK[0];
            end
          end
        end

        ST_SEED: begin
          phase_q  <= phase_d;
          tready_q <= tready_d;
          if (accept_d) begin
            word_cnt_q <= word_cnt_d;
            // An all-zero seed would lock the LFSR at zero forever, so it is rejected.
            if (s_axis_tdata == '0) begin
              err_cnt_q <= err_cnt_d;
            end else begin
              locked_q <= 1'b1;
              exp_q    <= data_chain[16];
              state_q  <= ST_CHECK;
            end
            if (last_d) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              tready_q <= 1'b0;
            end
          end
        end

        ST_CHECK: begin
          phase_q  <= phase_d;
          tready_q <= tready_d;
          if (accept_d) begin
            word_cnt_q <= word_cnt_d;
            exp_q      <= exp_d;
            if (mismatch_d) begin
              err_cnt_q <= err_cnt_d;
            end
            if (last_d) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              tready_q <= 1'b0;
            end
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          tready_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign locked        = locked_q;
  assign done          = done_q;
  assign pass          = done_q & (err_cnt_q == 16'd0);
  assign word_cnt      = word_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_axis_prbs_checker.sv
// Directed bench for axis_prbs_checker: one full-rate instance and one with an alternating ready mask.
module tb_axis_prbs_checker;

  localparam logic [7:0] MASK_B = 8'b1010_1010;
`ifdef AXIS_PRBS_CHK_RESYNC_EN
  localparam int CORRUPT_ERRS = 2;
`else
  localparam int CORRUPT_ERRS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [31:0] num_words;
  logic        tvalid_a, tvalid_b;
  logic [15:0] tdata_a, tdata_b;

  logic        tready_a, locked_a, done_a, pass_a;
  logic [31:0] word_cnt_a;
  logic [15:0] err_cnt_a;
  logic        tready_b, locked_b, done_b, pass_b;
  logic [31:0] word_cnt_b;
  logic [15:0] err_cnt_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] stim [0:15];

  always #5 clk = ~clk;

  axis_prbs_checker #(.DATA_W(16), .READY_MASK(8'hFF)) dut_a (
    .s_axis_aclk(clk), .rst(rst), .start(start_a), .num_words(num_words),
    .s_axis_tvaild(tvalid_a), .s_axis_tready(tready_a), .s_axis_tdata(tdata_a),
    .locked(locked_a), .done(done_a), .pass(pass_a),
    .word_cnt(word_cnt_a), .err_cnt(err_cnt_a)
  );

  axis_prbs_checker #(.DATA_W(16), .READY_MASK(MASK_B)) dut_b (
    .s_axis_aclk(clk), .rst(rst), .start(start_b), .num_words(num_words),
    .s_axis_tvaild(tvalid_b), .s_axis_tready(tready_b), .s_axis_tdata(tdata_b),
    .locked(locked_b), .done(done_b), .pass(pass_b),
    .word_cnt(word_cnt_b), .err_cnt(err_cnt_b)
  );

  function automatic logic [15:0] prbs_next(input logic [15:0] w);
    logic [15:0] r;
    r = w;
    for (int s = 0; s < 16; s++) begin
      r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_clean;
    stim[0] = 16'h0001;
    stim[1] = 16'h002D;
    stim[2] = 16'h0451;
    stim[3] = 16'hBDAD;
  endtask

  // Holds each word until the checker accepts it; gives up after budget cycles.
  task automatic run_a(input int n, input int budget);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    tvalid_a = 1'b1;
    while (idx < n && cyc < budget) begin
      tdata_a = stim[idx];
      if (tready_a) idx++;
      tick();
      cyc++;
    end
    tvalid_a = 1'b0;
    check("run_a_beats", idx, n);
  endtask

  task automatic pulse_start_a(input logic [31:0] n);
    num_words = n;
    start_a   = 1'b1;
    tick();
    start_a   = 1'b0;
  endtask

  initial begin
    logic [7:0] mb;
    int idx;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; num_words = 32'd0;
    tvalid_a = 1'b0; tvalid_b = 1'b0; tdata_a = 16'h0; tdata_b = 16'h0;
    load_clean();

    // Reset state
    tick(); tick();
    check("rst_tready", tready_a, 1'b0);
    check("rst_locked", locked_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_pass", pass_a, 1'b0);
    check("rst_word_cnt", word_cnt_a, 32'd0);
    check("rst_err_cnt", err_cnt_a, 16'd0);
    rst = 1'b0;
    tick();
    check("idle_tready", tready_a, 1'b0);

    // Clean run: 4 beats on 4 consecutive cycles
    pulse_start_a(32'd4);
    check("clean_tready_first", tready_a, 1'b1);
    check("clean_word_cnt0", word_cnt_a, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tvalid_a = 1'b1;
      tdata_a  = stim[i];
      tick();
      check($sformatf("clean_word_cnt%0d", i + 1), word_cnt_a, i + 1);
      check($sformatf("clean_locked%0d", i + 1), locked_a, 1'b1);
      check($sformatf("clean_done%0d", i + 1), done_a, (i == 3));
      check($sformatf("clean_tready%0d", i + 1), tready_a, (i != 3));
    end
    tvalid_a = 1'b0;
    check("clean_pass", pass_a, 1'b1);
    check("clean_err_cnt", err_cnt_a, 16'd0);
    tick();
    check("clean_word_cnt_hold", word_cnt_a, 32'd4);

    // Corruption of the third word
    stim[2] = 16'h0451 ^ 16'h0100;
    pulse_start_a(32'd4);
    run_a(4, 20);
    check("corrupt_done", done_a, 1'b1);
    check("corrupt_word_cnt", word_cnt_a, 32'd4);
    check("corrupt_err_cnt", err_cnt_a, CORRUPT_ERRS);
    check("corrupt_pass", pass_a, 1'b0);
    load_clean();

    // Zero seed
    pulse_start_a(32'd3);
    tvalid_a = 1'b1;
    tdata_a  = 16'h0000;
    tick();
    check("zero_locked1", locked_a, 1'b0);
    check("zero_err1", err_cnt_a, 16'd1);
    check("zero_word1", word_cnt_a, 32'd1);
    tdata_a = 16'h0001;
    tick();
    check("zero_locked2", locked_a, 1'b1);
    check("zero_err2", err_cnt_a, 16'd1);
    tdata_a = 16'h002D;
    tick();
    tvalid_a = 1'b0;
    check("zero_done", done_a, 1'b1);
    check("zero_word3", word_cnt_a, 32'd3);
    check("zero_err3", err_cnt_a, 16'd1);
    check("zero_pass", pass_a, 1'b0);

    // num_words = 0 finishes immediately without accepting a beat
    tvalid_a = 1'b1;
    tdata_a  = 16'h0001;
    pulse_start_a(32'd0);
    check("n0_done", done_a, 1'b1);
    check("n0_tready", tready_a, 1'b0);
    check("n0_word_cnt", word_cnt_a, 32'd0);
    tick(); tick();
    check("n0_word_cnt_hold", word_cnt_a, 32'd0);
    check("n0_locked", locked_a, 1'b0);
    tvalid_a = 1'b0;

    // start during CHECK is ignored
    pulse_start_a(32'd4);
    tvalid_a = 1'b1;
    tdata_a = stim[0]; tick();
    tdata_a = stim[1]; tick();
    num_words = 32'd1;
    start_a = 1'b1;
    tdata_a = stim[2]; tick();
    start_a = 1'b0;
    check("ign_word_cnt", word_cnt_a, 32'd3);
    check("ign_locked", locked_a, 1'b1);
    tdata_a = stim[3]; tick();
    tvalid_a = 1'b0;
    check("ign_done", done_a, 1'b1);
    check("ign_word_cnt_end", word_cnt_a, 32'd4);
    check("ign_pass", pass_a, 1'b1);

    // Asynchronous reset mid-CHECK
    pulse_start_a(32'd8);
    tvalid_a = 1'b1;
    tdata_a = stim[0]; tick();
    tdata_a = stim[1]; tick();
    rst = 1'b1;
    #1;
    check("arst_tready", tready_a, 1'b0);
    check("arst_locked", locked_a, 1'b0);
    check("arst_word_cnt", word_cnt_a, 32'd0);
    check("arst_err_cnt", err_cnt_a, 16'd0);
    check("arst_done", done_a, 1'b0);
    check("arst_pass", pass_a, 1'b0);
    tick();
    rst = 1'b0;
    tvalid_a = 1'b0;
    tick();
    check("arst_idle_tready", tready_a, 1'b0);

    // Backpressure with alternating ready mask
    stim[0] = 16'h0001;
    for (int i = 1; i < 8; i++) stim[i] = prbs_next(stim[i - 1]);
    mb = MASK_B;
    num_words = 32'd8;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tvalid_b = 1'b1;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("bp_tready_c%0d", c), tready_b, mb[c % 8]);
      check($sformatf("bp_done_c%0d", c), done_b, 1'b0);
      tdata_b = stim[idx];
      if (tready_b && idx < 7) idx++;
      tick();
    end
    tvalid_b = 1'b0;
    check("bp_done", done_b, 1'b1);
    check("bp_tready_end", tready_b, 1'b0);
    check("bp_word_cnt", word_cnt_b, 32'd8);
    check("bp_err_cnt", err_cnt_b, 16'd0);
    check("bp_pass", pass_b, 1'b1);
    check("bp_locked", locked_b, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
